// File: rtl/raydir_stepper.sv
// Per-line ray direction generator: snapshots the view vectors on i_frame_start and
// sweeps LINES rays across the view plane. RAYDIR_REVERSE_EN mirrors the sweep direction.

`ifndef F
`define F [20:0]
`endif

module raydir_stepper #(
    parameter int LINES      = 480,
    parameter int STEP_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic `F     facingX,
    input  logic `F     facingY,
    input  logic `F     vplaneX,
    input  logic `F     vplaneY,
    input  logic        i_frame_start,
    input  logic        i_ray_take,
    output logic        o_ray_valid,
    output logic `F     rayDirX,
    output logic `F     rayDirY,
    output logic [9:0]  o_line,
    output logic        o_frame_done,
    output logic [1:0]  fsm_state
);

    localparam int FW = $bits(facingX);
    localparam int AW = FW + STEP_SHIFT + 2;
    localparam logic [9:0] LAST_LINE = 10'(LINES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;
    logic   load, advance;

    logic signed [FW-1:0] step_x, step_y;
    logic signed [AW-1:0] acc_x, acc_y;
    logic signed [AW-1:0] start_x, start_y;
    logic signed [AW-1:0] next_x, next_y;

    function automatic logic signed [AW-1:0] sext(input logic [FW-1:0] v);
        return {{(AW-FW){v[FW-1]}}, v};
    endfunction

    // Accumulators hold ray * 2^STEP_SHIFT, so the per-line step is vplane unscaled.
`ifdef RAYDIR_REVERSE_EN
    assign start_x = (sext(facingX) + sext(vplaneX)) <<< STEP_SHIFT;
    assign start_y = (sext(facingY) + sext(vplaneY)) <<< STEP_SHIFT;
    assign next_x  = acc_x - sext(step_x);
    assign next_y  = acc_y - sext(step_y);
`else
    assign start_x = (sext(facingX) - sext(vplaneX)) <<< STEP_SHIFT;
    assign start_y = (sext(facingY) - sext(vplaneY)) <<< STEP_SHIFT;
    assign next_x  = acc_x + sext(step_x);
    assign next_y  = acc_y + sext(step_y);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame start pre-empts any take in the same cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        if (i_frame_start) begin
            load       = 1'b1;
            state_next = ACTIVE;
        end else begin
            unique case (state)
                ACTIVE: begin
                    if (i_ray_take) begin
                        if (o_line == LAST_LINE) begin
                            state_next = DONE;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_x <= '0;
            step_y <= '0;
            acc_x  <= '0;
            acc_y  <= '0;
            o_line <= '0;
        end else if (load) begin
            step_x <= vplaneX;
            step_y <= vplaneY;
            acc_x  <= start_x;
            acc_y  <= start_y;
            o_line <= '0;
        end else if (advance) begin
            acc_x  <= next_x;
            acc_y  <= next_y;
            o_line <= o_line + 10'd1;
        end
    end

    // Arithmetic shift floors toward minus infinity.
    assign rayDirX      = FW'(acc_x >>> STEP_SHIFT);
    assign rayDirY      = FW'(acc_y >>> STEP_SHIFT);
    assign o_ray_valid  = (state == ACTIVE);
    assign o_frame_done = (state == DONE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_raydir_stepper.sv
// Bench for raydir_stepper: constant vectors for known frames, hand sequences for
// frame end / restart / reset, and randomized frames against a line-formula model.

module tb_raydir_stepper;

    localparam int LINES = 480;
    localparam int SS    = 8;
    localparam int FW    = 21;
`ifdef RAYDIR_REVERSE_EN
    localparam longint DIR = -1;
`else
    localparam longint DIR = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, i_frame_start, i_ray_take;
    logic [FW-1:0] facingX, facingY, vplaneX, vplaneY;
    logic          o_ray_valid, o_frame_done;
    logic [FW-1:0] rayDirX, rayDirY;
    logic [9:0]    o_line;
    logic [1:0]    fsm_state;

    raydir_stepper #(.LINES(LINES), .STEP_SHIFT(SS)) dut (
        .clk(clk), .reset(reset),
        .facingX(facingX), .facingY(facingY), .vplaneX(vplaneX), .vplaneY(vplaneY),
        .i_frame_start(i_frame_start), .i_ray_take(i_ray_take),
        .o_ray_valid(o_ray_valid), .rayDirX(rayDirX), .rayDirY(rayDirY),
        .o_line(o_line), .o_frame_done(o_frame_done), .fsm_state(fsm_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: snapshot vectors, current line index, phase (0 idle, 1 active, 2 done).
    longint m_fx, m_fy, m_vx, m_vy;
    int     m_n, m_phase;
    logic [53:0] exp_q[$];

    // Ray for line n: linear interpolation from facing -/+ vplane, floored at 2^-SS resolution.
    function automatic longint model_ray(longint f, longint v, int n);
        longint scale = longint'(1) << SS;
        return ((f - DIR * v) * scale + DIR * longint'(n) * v) >>> SS;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int fx, input int fy, input int vx, input int vy);
        facingX = FW'(fx);
        facingY = FW'(fy);
        vplaneX = FW'(vx);
        vplaneY = FW'(vy);
    endtask

    task automatic model_update(input logic rst, input logic st, input logic tk);
        logic [FW-1:0] ex, ey;
        if (rst) begin
            m_fx = 0; m_fy = 0; m_vx = 0; m_vy = 0;
            m_n = 0; m_phase = 0;
        end else if (st) begin
            m_fx = longint'($signed(facingX));
            m_fy = longint'($signed(facingY));
            m_vx = longint'($signed(vplaneX));
            m_vy = longint'($signed(vplaneY));
            m_n = 0; m_phase = 1;
        end else if (m_phase == 1 && tk) begin
            if (m_n == LINES - 1) m_phase = 2;
            else m_n++;
        end
        ex = FW'(model_ray(m_fx, m_vx, m_n));
        ey = FW'(model_ray(m_fy, m_vy, m_n));
        exp_q.push_back({m_phase == 1, m_phase == 2, 10'(m_n), ex, ey});
    endtask

    // One clock: drive inputs, predict, then compare every output at the falling edge.
    task automatic cycle(input logic rst, input logic st, input logic tk);
        logic [53:0]   e;
        logic [FW-1:0] ex, ey;
        reset = rst; i_frame_start = st; i_ray_take = tk;
        model_update(rst, st, tk);
        @(negedge clk);
        e  = exp_q.pop_front();
        ex = e[41:21];
        ey = e[20:0];
        chk("valid", longint'(o_ray_valid), longint'(e[53]));
        chk("frame_done", longint'(o_frame_done), longint'(e[52]));
        chk("line", longint'(o_line), longint'(e[51:42]));
        chk("ray_x", longint'($signed(rayDirX)), longint'($signed(ex)));
        chk("ray_y", longint'($signed(rayDirY)), longint'($signed(ey)));
    endtask

    task automatic advance_to(input int target);
        while (m_phase == 1 && m_n < target) cycle(1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        string  name;
        int     line;
        longint ex;
        longint ey;
    } vec_t;

    vec_t tbl[4];

    initial begin
`ifdef RAYDIR_REVERSE_EN
        tbl[0] = '{"line0",   0,   1024,  512};
        tbl[1] = '{"line1",   1,   1024,  510};
        tbl[2] = '{"line256", 256, 1024,  0};
        tbl[3] = '{"line479", 479, 1024, -446};
`else
        tbl[0] = '{"line0",   0,   1024, -512};
        tbl[1] = '{"line1",   1,   1024, -510};
        tbl[2] = '{"line256", 256, 1024,  0};
        tbl[3] = '{"line479", 479, 1024,  446};
`endif
        set_vec(0, 0, 0, 0);

        // Reset and idle with takes ignored.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        chk("idle_valid", longint'(o_ray_valid), 0);
        chk("idle_done", longint'(o_frame_done), 0);
        chk("idle_line", longint'(o_line), 0);
        chk("idle_ray_x", longint'($signed(rayDirX)), 0);
        chk("idle_ray_y", longint'($signed(rayDirY)), 0);

        // Known frame: constant expectations at selected lines.
        set_vec(1024, 0, 0, 512);
        cycle(1'b0, 1'b1, 1'b0);
        set_vec(-7, 300, 12, -99);
        for (int k = 0; k < 4; k++) begin
            advance_to(tbl[k].line);
            chk({tbl[k].name, "_valid"}, longint'(o_ray_valid), 1);
            chk({tbl[k].name, "_idx"}, longint'(o_line), longint'(tbl[k].line));
            chk({tbl[k].name, "_x"}, longint'($signed(rayDirX)), tbl[k].ex);
            chk({tbl[k].name, "_y"}, longint'($signed(rayDirY)), tbl[k].ey);
            if (k == 2) begin
                for (int i = 0; i < 3; i++) begin
                    set_vec(int'($urandom_range(0, 4095)), 5, 6, int'($urandom_range(0, 4095)));
                    cycle(1'b0, 1'b0, 1'b0);
                end
            end
        end

        // Last take ends the frame; further takes change nothing.
        cycle(1'b0, 1'b0, 1'b1);
        chk("end_valid", longint'(o_ray_valid), 0);
        chk("end_done", longint'(o_frame_done), 1);
        chk("end_line", longint'(o_line), 479);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("end_hold_line", longint'(o_line), 479);

        // Floor behaviour with a one-LSB plane.
        set_vec(0, 0, 0, 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("floor_line0", longint'($signed(rayDirY)), -DIR);
        advance_to(255);
        chk("floor_line255", longint'($signed(rayDirY)), (DIR == 1) ? -1 : 0);
        advance_to(256);
        chk("floor_line256", longint'($signed(rayDirY)), 0);
        advance_to(479);

        // Restart mid-frame with a simultaneous take, then reset mid-frame.
        set_vec(1024, 0, 0, 512);
        cycle(1'b0, 1'b1, 1'b0);
        advance_to(100);
        set_vec(0, 1024, -512, 0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("restart_line", longint'(o_line), 0);
        chk("restart_x", longint'($signed(rayDirX)), (DIR == 1) ? 512 : -512);
        chk("restart_y", longint'($signed(rayDirY)), 1024);
        advance_to(5);
        cycle(1'b1, 1'b1, 1'b1);
        chk("rst_mid_valid", longint'(o_ray_valid), 0);
        chk("rst_mid_line", longint'(o_line), 0);
        chk("rst_mid_x", longint'($signed(rayDirX)), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // Randomized frames with random takes, junk inputs, rare restarts and resets.
        for (int f = 0; f < 6; f++) begin
            set_vec(int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144,
                    int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144);
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 1500 && m_phase != 2; c++) begin
                set_vec(int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144,
                        int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144);
                cycle(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 399) == 0),
                      1'($urandom_range(0, 3) != 0));
                if (m_phase == 0) cycle(1'b0, 1'b1, 1'b0);
            end
            cycle(1'b0, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
